// File: rtl/stream_addr_route.sv
// rtl/stream_addr_route.sv - address-decoded 1-to-N stream router with 2-entry skid buffer
// Optional: define STREAM_ADDR_ROUTE_ERR_CNT_EN to build the saturating decode-error counter.
module stream_addr_route #(
  parameter int NoOutputs = 4,
  parameter int NoRules   = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  localparam int SelW     = $clog2(NoOutputs)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [AddrWidth-1:0]              inp_addr_i,
  input  logic [DataWidth-1:0]              inp_data_i,
  input  logic                              inp_valid_i,
  output logic                              inp_ready_o,
  input  logic [NoRules-1:0][SelW-1:0]      rule_idx_i,
  input  logic [NoRules-1:0][AddrWidth-1:0] rule_start_i,
  input  logic [NoRules-1:0][AddrWidth-1:0] rule_end_i,
  input  logic                              default_en_i,
  input  logic [SelW-1:0]                   default_idx_i,
  output logic [AddrWidth-1:0]              oup_addr_o,
  output logic [DataWidth-1:0]              oup_data_o,
  output logic [NoOutputs-1:0]              oup_valid_o,
  input  logic [NoOutputs-1:0]              oup_ready_i,
  output logic [SelW-1:0]                   oup_sel_o,
  output logic                              err_o,
  output logic [AddrWidth-1:0]              err_addr_o,
  output logic [15:0]                       err_cnt_o
);

  // Output count widened by one bit so indices can be range-checked for any NoOutputs.
  localparam logic [SelW:0] NoOutW = (SelW + 1)'(NoOutputs);

  typedef struct packed {
    logic                 v;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
    logic [SelW-1:0]      sel;
  } entry_t;

  entry_t          e0_q, e1_q, e0_n, e1_n, new_e;
  logic            ready_q;
  logic            err_q;
  logic [AddrWidth-1:0] err_addr_q;
  logic            hit;
  logic [SelW-1:0] hit_idx;
  logic            route_ok;
  logic [SelW-1:0] route_sel;
  logic            accept, push, pop, err_ev;

  // Address decode: highest-index valid rule wins, then the default route if usable.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    route_ok  = 1'b0;
    route_sel = '0;
    for (int r = 0; r < NoRules; r++) begin
      if ((rule_start_i[r] < rule_end_i[r]) &&
          (inp_addr_i >= rule_start_i[r]) &&
          (inp_addr_i < rule_end_i[r]) &&
          ({1'b0, rule_idx_i[r]} < NoOutW)) begin
        hit     = 1'b1;
        hit_idx = rule_idx_i[r];
      end
    end
    if (hit) begin
      route_ok  = 1'b1;
      route_sel = hit_idx;
    end else if (default_en_i && ({1'b0, default_idx_i} < NoOutW)) begin
      route_ok  = 1'b1;
      route_sel = default_idx_i;
    end
  end

  assign accept = inp_valid_i & ready_q;
  assign push   = accept & route_ok;
  assign err_ev = accept & ~route_ok;
  assign pop    = e0_q.v & oup_ready_i[e0_q.sel];

  // Skid buffer next state: e0 is the presented head, e1 only fills when the head stalls.
  always_comb begin
    new_e      = '0;
    new_e.v    = 1'b1;
    new_e.addr = inp_addr_i;
    new_e.data = inp_data_i;
    new_e.sel  = route_sel;
    e0_n       = e0_q;
    e1_n       = e1_q;
    if (pop) begin
      if (e1_q.v) begin
        e0_n   = e1_q;
        e1_n.v = 1'b0;
        if (push) e1_n = new_e;
      end else begin
        e0_n.v = 1'b0;
        if (push) e0_n = new_e;
      end
    end else if (push) begin
      if (!e0_q.v) e0_n = new_e;
      else         e1_n = new_e;
    end
  end

  // Buffer, registered ready and decode-error pulse/address state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      e0_q       <= '0;
      e1_q       <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      e0_q    <= e0_n;
      e1_q    <= e1_n;
      ready_q <= ~e1_n.v;
      err_q   <= err_ev;
      if (err_ev) err_addr_q <= inp_addr_i;
    end
  end

  // Only the selected output sees valid; all outputs share address and data.
  always_comb begin
    oup_valid_o = '0;
    if (e0_q.v) oup_valid_o[e0_q.sel] = 1'b1;
  end

  assign inp_ready_o = ready_q;
  assign oup_addr_o  = e0_q.addr;
  assign oup_data_o  = e0_q.data;
  assign oup_sel_o   = e0_q.sel;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;

`ifdef STREAM_ADDR_ROUTE_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of decode errors.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (err_ev && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_addr_route.sv
// tb/tb_stream_addr_route.sv - directed self-checking bench for stream_addr_route
module tb_stream_addr_route;

  logic             clk;
  logic             rst_ni;
  logic [31:0]      inp_addr;
  logic [31:0]      inp_data;
  logic             inp_valid;
  logic             inp_ready;
  logic [3:0][1:0]  rule_idx;
  logic [3:0][31:0] rule_start;
  logic [3:0][31:0] rule_end;
  logic             default_en;
  logic [1:0]       default_idx;
  logic [31:0]      oup_addr;
  logic [31:0]      oup_data;
  logic [3:0]       oup_valid;
  logic [3:0]       oup_ready;
  logic [1:0]       oup_sel;
  logic             err;
  logic [31:0]      err_addr;
  logic [15:0]      err_cnt;

  int checks;
  int errors;
  int exp_cnt;

  stream_addr_route dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .inp_addr_i   (inp_addr),
    .inp_data_i   (inp_data),
    .inp_valid_i  (inp_valid),
    .inp_ready_o  (inp_ready),
    .rule_idx_i   (rule_idx),
    .rule_start_i (rule_start),
    .rule_end_i   (rule_end),
    .default_en_i (default_en),
    .default_idx_i(default_idx),
    .oup_addr_o   (oup_addr),
    .oup_data_o   (oup_data),
    .oup_valid_o  (oup_valid),
    .oup_ready_i  (oup_ready),
    .oup_sel_o    (oup_sel),
    .err_o        (err),
    .err_addr_o   (err_addr),
    .err_cnt_o    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rules();
    rule_idx   = '0;
    rule_start = '0;
    rule_end   = '0;
  endtask

  task automatic set_rule(input int r, input logic [31:0] s, input logic [31:0] e,
                          input logic [1:0] idx);
    rule_start[r] = s;
    rule_end[r]   = e;
    rule_idx[r]   = idx;
  endtask

  task automatic note_error();
`ifdef STREAM_ADDR_ROUTE_ERR_CNT_EN
    exp_cnt++;
`endif
  endtask

  function automatic logic [31:0] beat_addr(input int k);
    return (k % 2 == 1) ? (32'h1000 + 32'(k)) : 32'(k);
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        def_en;
    logic        exp_ok;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int sent, rx, occ;
    logic saw_full, do_acc, do_pop;

    checks = 0; errors = 0; exp_cnt = 0;
    rst_ni = 1'b0; inp_valid = 1'b0; inp_addr = '0; inp_data = '0;
    default_en = 1'b0; default_idx = 2'd1; oup_ready = '1;
    clear_rules();

    vecs[0]  = '{32'h0000_0000, 1'b0, 1'b1, 2'd0};
    vecs[1]  = '{32'h0000_0FFF, 1'b0, 1'b1, 2'd0};
    vecs[2]  = '{32'h0000_1000, 1'b0, 1'b1, 2'd2};
    vecs[3]  = '{32'h0000_13FF, 1'b0, 1'b1, 2'd2};
    vecs[4]  = '{32'h0000_1400, 1'b0, 1'b1, 2'd3};
    vecs[5]  = '{32'h0000_14FF, 1'b0, 1'b1, 2'd3};
    vecs[6]  = '{32'h0000_1500, 1'b0, 1'b1, 2'd2};
    vecs[7]  = '{32'h0000_1FFF, 1'b0, 1'b1, 2'd2};
    vecs[8]  = '{32'h0000_2000, 1'b1, 1'b1, 2'd1};
    vecs[9]  = '{32'h0000_9000, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{32'h0000_3000, 1'b1, 1'b1, 2'd1};
    vecs[11] = '{32'h0000_2000, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{32'h0000_0800, 1'b1, 1'b1, 2'd0};

    // Reset state
    repeat (3) tick();
    chk("rst_ready", inp_ready, 0);
    chk("rst_valid", oup_valid, 0);
    chk("rst_sel", oup_sel, 0);
    chk("rst_err", err, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_ni = 1'b1;
    tick();
    chk("rel_ready", inp_ready, 1);

    // Decode table: rule 2 overlaps rule 1, rule 3 is empty and must be ignored
    set_rule(0, 32'h0000, 32'h1000, 2'd0);
    set_rule(1, 32'h1000, 32'h2000, 2'd2);
    set_rule(2, 32'h1400, 32'h1500, 2'd3);
    set_rule(3, 32'h3000, 32'h3000, 2'd3);
    for (int i = 0; i < 13; i++) begin
      inp_addr   = vecs[i].addr;
      inp_data   = 32'hD000_0000 | 32'(i);
      default_en = vecs[i].def_en;
      inp_valid  = 1'b1;
      chk($sformatf("v%0d_pre_valid", i), oup_valid, 0);
      tick();
      inp_valid = 1'b0;
      if (vecs[i].exp_ok) begin
        chk($sformatf("v%0d_valid", i), oup_valid, 64'(4'b0001 << vecs[i].exp_sel));
        chk($sformatf("v%0d_sel", i), oup_sel, vecs[i].exp_sel);
        chk($sformatf("v%0d_addr", i), oup_addr, vecs[i].addr);
        chk($sformatf("v%0d_data", i), oup_data, 32'hD000_0000 | 32'(i));
        chk($sformatf("v%0d_err", i), err, 0);
      end else begin
        note_error();
        chk($sformatf("v%0d_valid", i), oup_valid, 0);
        chk($sformatf("v%0d_err", i), err, 1);
        chk($sformatf("v%0d_err_addr", i), err_addr, vecs[i].addr);
      end
      chk($sformatf("v%0d_err_cnt", i), err_cnt, 16'(exp_cnt));
      tick();
      chk($sformatf("v%0d_post_valid", i), oup_valid, 0);
      chk($sformatf("v%0d_post_err", i), err, 0);
    end
    chk("err_addr_held", err_addr, 32'h2000);
    default_en = 1'b0;

    // Two-rule map, 0x1800 -> output 2 one cycle after accept
    clear_rules();
    set_rule(0, 32'h0000, 32'h1000, 2'd0);
    set_rule(1, 32'h1000, 32'h2000, 2'd2);
    inp_addr = 32'h1800; inp_data = 32'h1234; inp_valid = 1'b1;
    tick();
    inp_valid = 1'b0;
    chk("map2_valid", oup_valid, 4'b0100);
    chk("map2_sel", oup_sel, 2);
    tick();

    // Overlapping rules: higher index wins
    clear_rules();
    set_rule(0, 32'h0000, 32'h2000, 2'd1);
    set_rule(1, 32'h1000, 32'h1800, 2'd3);
    inp_addr = 32'h1400; inp_data = 32'h5678; inp_valid = 1'b1;
    tick();
    inp_valid = 1'b0;
    chk("ovl_valid", oup_valid, 4'b1000);
    chk("ovl_sel", oup_sel, 3);
    tick();

    // Stall on selected output, unselected readies ignored, map change does not reroute
    clear_rules();
    set_rule(0, 32'h0000, 32'h1000, 2'd2);
    oup_ready = 4'b1011;
    inp_addr = 32'h40; inp_data = 32'hCAFE; inp_valid = 1'b1;
    tick();
    inp_valid = 1'b0;
    chk("hold_valid0", oup_valid, 4'b0100);
    set_rule(0, 32'h0000, 32'h1000, 2'd3);
    tick();
    chk("hold_valid1", oup_valid, 4'b0100);
    chk("hold_sel", oup_sel, 2);
    chk("hold_addr", oup_addr, 32'h40);
    chk("hold_data", oup_data, 32'hCAFE);
    oup_ready = 4'b0100;
    tick();
    chk("hold_drain", oup_valid, 0);

    // 8 alternating beats, output 1 stalls 3 cycles
    clear_rules();
    set_rule(0, 32'h0000, 32'h1000, 2'd0);
    set_rule(1, 32'h1000, 32'h2000, 2'd1);
    oup_ready = '1;
    sent = 0; rx = 0; occ = 0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      oup_ready[1] = !(cyc >= 2 && cyc <= 4);
      inp_valid    = (sent < 8);
      inp_addr     = beat_addr(sent);
      inp_data     = 32'hA0 + 32'(sent);
      chk("seq_ready", inp_ready, (occ != 2));
      chk("seq_any_valid", (oup_valid != 0), (occ != 0));
      if (!inp_ready) saw_full = 1'b1;
      do_acc = inp_valid && inp_ready;
      do_pop = 1'b0;
      if (occ != 0) begin
        chk("seq_valid", oup_valid, 64'(4'b0001 << (rx % 2)));
        chk("seq_sel", oup_sel, 64'(rx % 2));
        chk("seq_addr", oup_addr, beat_addr(rx));
        chk("seq_data", oup_data, 32'hA0 + 32'(rx));
        do_pop = oup_ready[rx % 2];
      end
      tick();
      if (do_acc) begin sent++; occ++; end
      if (do_pop) begin rx++; occ--; end
    end
    inp_valid = 1'b0;
    chk("seq_rx_count", rx, 8);
    chk("seq_saw_full", saw_full, 1);

    // Reset with two beats buffered
    oup_ready = '0;
    inp_addr = 32'h10; inp_data = 32'h1; inp_valid = 1'b1;
    tick();
    inp_addr = 32'h20; inp_data = 32'h2;
    tick();
    inp_valid = 1'b0;
    chk("full_ready", inp_ready, 0);
    chk("full_valid", oup_valid, 4'b0001);
    rst_ni = 1'b0;
    tick();
    chk("mrst_valid", oup_valid, 0);
    chk("mrst_ready", inp_ready, 0);
    rst_ni = 1'b1;
    oup_ready = '1;
    tick();
    chk("mrst_rel_ready", inp_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("mrst_no_stale", oup_valid, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
